// File: rtl/mem_port_pkg.sv
// Shared types for the memory-port responder: FSM states and the captured request.
package mem_port_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_port_state_t;

    typedef struct packed {
        logic [31:0]           addr;
        logic                  wr;
        logic [31:0]           data;
        logic [WORD_BYTES-1:0] byte_en;
    } mem_port_req_t;

endpackage

// File: rtl/mem_port_responder_if.sv
// Request/response bus between the core's memory initiator and the responder.
// Defining MEM_PORT_BYTE_EN adds the ByteEn write-lane qualifier.
interface mem_port_responder_if;
    logic        Req;
    logic        Wr;
    logic [31:0] Address;
    logic [31:0] Datain;
    logic [31:0] Dataout;
    logic        Ready;
    logic        AddrError;
    logic        Busy;
`ifdef MEM_PORT_BYTE_EN
    logic [3:0]  ByteEn;

    modport master (output Req, Wr, Address, Datain, ByteEn,
                    input  Dataout, Ready, AddrError, Busy);
    modport slave  (input  Req, Wr, Address, Datain, ByteEn,
                    output Dataout, Ready, AddrError, Busy);
`else
    modport master (output Req, Wr, Address, Datain,
                    input  Dataout, Ready, AddrError, Busy);
    modport slave  (input  Req, Wr, Address, Datain,
                    output Dataout, Ready, AddrError, Busy);
`endif
endinterface

// File: rtl/mem_port_array.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port that can be forced to zero.
module mem_port_array
    import mem_port_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic [WORD_BYTES-1:0]    we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_port_responder.sv
// Responder end of the CPU memory port: fixed-latency word access with misalignment flag.
// Optional per-byte write lanes via MEM_PORT_BYTE_EN.
module mem_port_responder
    import mem_port_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input logic                 clock,
    input logic                 reset,
    mem_port_responder_if.slave port
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(LATENCY + 1);

    mem_port_state_t     state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    mem_port_req_t       req_q, in_req, cur_req;
    logic                accept, enter_resp, misaligned;
    logic                rd_en, clr;
    logic [WORD_BYTES-1:0] we;
    logic                unused_bits;

    always_comb begin
        in_req.addr = port.Address;
        in_req.wr   = port.Wr;
        in_req.data = port.Datain;
`ifdef MEM_PORT_BYTE_EN
        in_req.byte_en = port.ByteEn;
`else
        in_req.byte_en = '1;
`endif
    end

    assign accept = port.Req && (state_q == IDLE || state_q == RESP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (!accept) begin
                    state_d = IDLE;
                end else if (LATENCY == 1) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CW'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY=1 the edge entering RESP is also the accepting edge, so the
    // array must be driven from the live bus rather than the captured request.
    assign cur_req     = (state_q == WAIT) ? req_q : in_req;
    assign enter_resp  = (state_d == RESP) && !reset;
    assign misaligned  = (cur_req.addr[1:0] != 2'b00);
    assign we          = (enter_resp && cur_req.wr && !misaligned) ? cur_req.byte_en : '0;
    assign rd_en       = enter_resp && !cur_req.wr && !misaligned;
    assign clr         = enter_resp && misaligned;
    assign unused_bits = ^cur_req.addr[31:AW+2];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_q <= in_req;
            end
        end
    end

    mem_port_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clock),
        .rst   (reset),
        .en    (rd_en),
        .clr   (clr),
        .we    (we),
        .addr  (cur_req.addr[AW+1:2]),
        .wdata (cur_req.data),
        .rdata (port.Dataout)
    );

    assign port.Ready     = (state_q == RESP);
    assign port.AddrError = (state_q == RESP) && (req_q.addr[1:0] != 2'b00);
    assign port.Busy      = (state_q == WAIT);

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed self-checking bench for mem_port_responder (DEPTH=256, LATENCY=2).
module tb_mem_port_responder;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] dout_model = 32'h0;

    mem_port_responder_if bus ();

    mem_port_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clock (clock),
        .reset (reset),
        .port  (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated access from IDLE; rd_exp is the word a read must return.
    task automatic access(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be,
                          input logic [31:0] rd_exp);
        logic mis;
        mis = (addr[1:0] != 2'b00);
        bus.Req = 1'b1; bus.Wr = wr; bus.Address = addr; bus.Datain = data;
`ifdef MEM_PORT_BYTE_EN
        bus.ByteEn = be;
`else
        if (be != 4'hF) $display("note: ByteEn ignored in this build");
`endif
        @(posedge clock); #1;
        bus.Req = 1'b0; bus.Wr = 1'b0;
        check({tag, ".wait_ready"}, {31'b0, bus.Ready}, 32'h0);
        check({tag, ".wait_busy"},  {31'b0, bus.Busy},  32'h1);
        check({tag, ".wait_err"},   {31'b0, bus.AddrError}, 32'h0);
        @(posedge clock); #1;
        if (mis) dout_model = 32'h0;
        else if (!wr) dout_model = rd_exp;
        check({tag, ".ready"}, {31'b0, bus.Ready}, 32'h1);
        check({tag, ".err"},   {31'b0, bus.AddrError}, {31'b0, mis});
        check({tag, ".busy"},  {31'b0, bus.Busy}, 32'h0);
        check({tag, ".dout"},  bus.Dataout, dout_model);
        @(posedge clock); #1;
        check({tag, ".idle_ready"}, {31'b0, bus.Ready}, 32'h0);
        check({tag, ".idle_err"},   {31'b0, bus.AddrError}, 32'h0);
    endtask

    initial begin
        logic [31:0] b2b_data [4];
        b2b_data[0] = 32'h11111111;
        b2b_data[1] = 32'h22222222;
        b2b_data[2] = 32'h00000000;
        b2b_data[3] = 32'h44444444;

        bus.Req = 1'b0; bus.Wr = 1'b0; bus.Address = '0; bus.Datain = '0;
`ifdef MEM_PORT_BYTE_EN
        bus.ByteEn = 4'hF;
`endif
        // Reset state
        @(posedge clock); @(posedge clock); #1;
        check("rst.ready", {31'b0, bus.Ready}, 32'h0);
        check("rst.err",   {31'b0, bus.AddrError}, 32'h0);
        check("rst.busy",  {31'b0, bus.Busy}, 32'h0);
        check("rst.dout",  bus.Dataout, 32'h0);
        reset = 1'b0;

        // Basic write then read
        access("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0);
        access("rd10", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF);

        // Misaligned write leaves the aligned word untouched
        access("wr20", 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0);
        access("mis22", 1'b1, 32'h22, 32'h12345678, 4'hF, 32'h0);
        access("rd20", 1'b0, 32'h20, 32'h0, 4'hF, 32'hCAFEF00D);
        access("misrd", 1'b0, 32'h13, 32'h0, 4'hF, 32'h0);

        // Preload for back-to-back reads
        for (int i = 0; i < 4; i++)
            access("pre", 1'b1, 32'(4 * i), b2b_data[i], 4'hF, 32'h0);

        // Back-to-back reads with Req held high; WAIT-cycle garbage must be ignored
        bus.Req = 1'b1; bus.Wr = 1'b0; bus.Address = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            check("b2b.wait_busy",  {31'b0, bus.Busy},  32'h1);
            check("b2b.wait_ready", {31'b0, bus.Ready}, 32'h0);
            bus.Wr = 1'b1; bus.Address = 32'h3; bus.Datain = 32'hFFFFFFFF;
            @(posedge clock); #1;
            check("b2b.ready", {31'b0, bus.Ready}, 32'h1);
            check("b2b.busy",  {31'b0, bus.Busy},  32'h0);
            check("b2b.err",   {31'b0, bus.AddrError}, 32'h0);
            check("b2b.dout",  bus.Dataout, b2b_data[k]);
            dout_model = b2b_data[k];
            bus.Wr = 1'b0;
            if (k < 3) bus.Address = 32'(4 * (k + 1));
            else bus.Req = 1'b0;
        end
        @(posedge clock); #1;
        check("b2b.idle_ready", {31'b0, bus.Ready}, 32'h0);
        access("b2b.rd0", 1'b0, 32'h0, 32'h0, 4'hF, 32'h11111111);

        // Address aliasing modulo DEPTH*4
        access("wr400", 1'b1, 32'h400, 32'hA5A5A5A5, 4'hF, 32'h0);
        access("rd000", 1'b0, 32'h000, 32'h0, 4'hF, 32'hA5A5A5A5);

        // Reset during WAIT drops the write
        bus.Req = 1'b1; bus.Wr = 1'b1; bus.Address = 32'h8; bus.Datain = 32'hFFFFFFFF;
        @(posedge clock); #1;
        bus.Req = 1'b0; bus.Wr = 1'b0;
        check("mrst.busy_before", {31'b0, bus.Busy}, 32'h1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        dout_model = 32'h0;
        check("mrst.ready", {31'b0, bus.Ready}, 32'h0);
        check("mrst.busy",  {31'b0, bus.Busy}, 32'h0);
        check("mrst.err",   {31'b0, bus.AddrError}, 32'h0);
        check("mrst.dout",  bus.Dataout, 32'h0);
        @(posedge clock); #1;
        check("mrst.no_ready", {31'b0, bus.Ready}, 32'h0);
        access("mrst.rd8", 1'b0, 32'h8, 32'h0, 4'hF, 32'h0);

`ifdef MEM_PORT_BYTE_EN
        access("be.full", 1'b1, 32'h4, 32'h11223344, 4'hF, 32'h0);
        access("be.part", 1'b1, 32'h4, 32'hAABBCCDD, 4'b0101, 32'h0);
        access("be.none", 1'b1, 32'h4, 32'h99999999, 4'b0000, 32'h0);
        access("be.rd",   1'b0, 32'h4, 32'h0, 4'b0000, 32'h11BB33DD);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
